glitch_pulse: RTL



---
 rtl/glitch_pkg.sv | 25 ++
 rtl/cycle_counter.sv | 42 ++++
 rtl/glitch_pulse.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/glitch_pkg.sv
// glitch_pkg: shared state encoding and default widths for the glitch pulse generator.
// Rev 1.0
`default_nettype none

package glitch_pkg;

  localparam int unsigned CNT_W_DEF = 16;
  localparam int unsigned NUM_W_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARMED    = 3'd1,
    ST_DELAY    = 3'd2,
    ST_PULSE    = 3'd3,
    ST_GAP      = 3'd4,
    ST_FINISHED = 3'd5
  } state_t;

  function automatic logic is_busy_state(input state_t s);
    return (s == ST_DELAY) || (s == ST_PULSE) || (s == ST_GAP);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cycle_counter.sv
// cycle_counter: loadable down-counter that holds at zero; shared by DELAY, PULSE and GAP.
// Rev 1.0
`default_nettype none

module cycle_counter
  import glitch_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  input  logic             en,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = value;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/glitch_pulse.sv
// glitch_pulse: after arming, waits for a trigger rising edge, delays, then emits
// num pulses of programmable width separated by programmable gaps. Rev 1.0
`default_nettype none

module glitch_pulse
  import glitch_pkg::*;
#(
  parameter int unsigned CNT_W        = CNT_W_DEF,
  parameter int unsigned NUM_W        = NUM_W_DEF,
  parameter bit          ACTIVE_LEVEL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arm,
  input  logic             trigger,
  input  logic [CNT_W-1:0] delay,
  input  logic [CNT_W-1:0] width,
  input  logic [CNT_W-1:0] gap,
  input  logic [NUM_W-1:0] num,
  output logic             glitch,
  output logic             busy,
  output logic             done
);

  state_t           state_q, state_d;
  logic             trig_prev_q;
  logic [CNT_W-1:0] delay_sh_q, delay_sh_d;
  logic [CNT_W-1:0] width_sh_q, width_sh_d;
  logic [CNT_W-1:0] gap_sh_q, gap_sh_d;
  logic [NUM_W-1:0] num_q, num_d;
  logic             glitch_q, glitch_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             trig_edge;
  logic [CNT_W-1:0] width_m1;
  logic [CNT_W-1:0] gap_m1;
  logic [NUM_W-1:0] num_dec;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_value;
  logic             cnt_en;
  logic             cnt_zero;

  // The shared counter runs N-1 down to 0, so a reload of N-1 yields N cycles
  // in the state; width/gap of 0 collapse to a single cycle.
  assign width_m1  = (width_sh_q == '0) ? '0 : width_sh_q - 1'b1;
  assign gap_m1    = (gap_sh_q == '0) ? '0 : gap_sh_q - 1'b1;
  assign num_dec   = (num_q == '0) ? '0 : num_q - 1'b1;
  assign trig_edge = trigger && !trig_prev_q;

  cycle_counter #(
    .CNT_W (CNT_W)
  ) u_cycle_counter (
    .clk   (clk),
    .rst   (rst),
    .load  (cnt_load),
    .value (cnt_value),
    .en    (cnt_en),
    .zero  (cnt_zero)
  );

  always_comb begin
    state_d    = state_q;
    delay_sh_d = delay_sh_q;
    width_sh_d = width_sh_q;
    gap_sh_d   = gap_sh_q;
    num_d      = num_q;
    cnt_load   = 1'b0;
    cnt_value  = '0;
    cnt_en     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (arm) begin
          delay_sh_d = delay;
          width_sh_d = width;
          gap_sh_d   = gap;
          num_d      = num;
          state_d    = ST_ARMED;
        end
      end

      ST_ARMED: begin
        // A dropped arm wins over a coincident edge: the output stays quiet.
        if (!arm) begin
          state_d = ST_IDLE;
        end else if (trig_edge) begin
          if (num_q == '0) begin
            state_d = ST_FINISHED;
          end else begin
            state_d   = ST_DELAY;
            cnt_load  = 1'b1;
            cnt_value = delay_sh_q;
          end
        end
      end

      ST_DELAY: begin
        if (cnt_zero) begin
          state_d   = ST_PULSE;
          cnt_load  = 1'b1;
          cnt_value = width_m1;
        end else begin
          cnt_en = 1'b1;
        end
      end

      ST_PULSE: begin
        if (cnt_zero) begin
          num_d = num_dec;
          if (num_dec != '0) begin
            state_d   = ST_GAP;
            cnt_load  = 1'b1;
            cnt_value = gap_m1;
          end else begin
            state_d = ST_FINISHED;
          end
        end else begin
          cnt_en = 1'b1;
        end
      end

      ST_GAP: begin
        if (cnt_zero) begin
          state_d   = ST_PULSE;
          cnt_load  = 1'b1;
          cnt_value = width_m1;
        end else begin
          cnt_en = 1'b1;
        end
      end

      ST_FINISHED: begin
        if (!arm) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they change on the same edge
    // as the state register while still coming straight out of flops.
    glitch_d = (state_d == ST_PULSE) ? ACTIVE_LEVEL : !ACTIVE_LEVEL;
    busy_d   = is_busy_state(state_d);
    done_d   = (state_d == ST_FINISHED);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      trig_prev_q <= 1'b0;
      delay_sh_q  <= '0;
      width_sh_q  <= '0;
      gap_sh_q    <= '0;
      num_q       <= '0;
      glitch_q    <= !ACTIVE_LEVEL;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      trig_prev_q <= trigger;
      delay_sh_q  <= delay_sh_d;
      width_sh_q  <= width_sh_d;
      gap_sh_q    <= gap_sh_d;
      num_q       <= num_d;
      glitch_q    <= glitch_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign glitch = glitch_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

`default_nettype wire
